// File: rtl/binary_clock_hm_counter.sv
// binary_clock_hm_counter: minutes/hours stage of the binary LED clock.
// Consumes the seconds stage's tick_minutes level, keeps minutes (0-59) and
// hours (0-23), and offers push-button time setting via a RUN/SET_H/SET_M FSM.
// Optional macro TWELVE_HOUR_EN: 12-hour display (hours 1-12) with a pm output.

// Per-button synchroniser, debouncer and press-edge detector.
module binary_clock_hm_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q, db_q, db_prev_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser, then count consecutive mismatches against the
  // debounced level; any agreement restarts the count.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_raw_i;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // One-clock pulse on debounced press only; release is silent.
  assign press_o = db_q & ~db_prev_q;
endmodule

module binary_clock_hm_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       tick_minutes,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [1:0] set_mode,
`ifdef TWELVE_HOUR_EN
  output logic       pm,
`endif
  output logic       day_tick
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10} state_t;

  state_t     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d, hr_inc;
  logic       day_q, day_d, hr_wrap;
  logic       tk1_q, tk2_q, tk3_q, minute_evt;
  logic [1:0] btn_raw, btn_press;
  logic       mode_press, inc_press;
`ifdef TWELVE_HOUR_EN
  logic       pm_q, pm_d, pm_inc;
`endif

  // Button index 0 = mode, 1 = inc.
  assign btn_raw = {btn_inc, btn_mode};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_btn
      binary_clock_hm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_raw_i  (btn_raw[g]),
        .press_o    (btn_press[g])
      );
    end
  endgenerate

  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1];

  // tick_minutes synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      tk1_q <= 1'b0;
      tk2_q <= 1'b0;
      tk3_q <= 1'b0;
    end else begin
      tk1_q <= tick_minutes;
      tk2_q <= tk1_q;
      tk3_q <= tk2_q;
    end
  end

  // Seconds 59->0 wrap shows up as the synchronised level falling.
  assign minute_evt = tk3_q & ~tk2_q;

  // Shared hour-increment rule for RUN carry and SET_H stepping.
  always_comb begin
`ifdef TWELVE_HOUR_EN
    hr_inc  = (hr_q == 5'd12) ? 5'd1 : hr_q + 5'd1;
    pm_inc  = (hr_q == 5'd11) ? ~pm_q : pm_q;
    hr_wrap = (hr_q == 5'd11) & pm_q;
`else
    hr_inc  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    hr_wrap = (hr_q == 5'd23);
`endif
  end

  // Next-state: a mode press always wins and swallows same-cycle inc/minute events.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    hr_d    = hr_q;
    day_d   = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d    = pm_q;
`endif
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        default: state_d = RUN;
      endcase
    end else begin
      case (state_q)
        RUN: if (minute_evt) begin
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            hr_d  = hr_inc;
            day_d = hr_wrap;
`ifdef TWELVE_HOUR_EN
            pm_d  = pm_inc;
`endif
          end else begin
            min_d = min_q + 6'd1;
          end
        end
        SET_H: if (inc_press) begin
          hr_d = hr_inc;
`ifdef TWELVE_HOUR_EN
          pm_d = pm_inc;
`endif
        end
        SET_M: if (inc_press) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        default: state_d = RUN;
      endcase
    end
  end

  // Time, mode and day_tick registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      min_q   <= 6'd0;
      day_q   <= 1'b0;
`ifdef TWELVE_HOUR_EN
      hr_q    <= 5'd12;
      pm_q    <= 1'b0;
`else
      hr_q    <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      day_q   <= day_d;
`ifdef TWELVE_HOUR_EN
      pm_q    <= pm_d;
`endif
    end
  end

  assign minutes  = min_q;
  assign hours    = hr_q;
  assign set_mode = state_q;
  assign day_tick = day_q;
`ifdef TWELVE_HOUR_EN
  assign pm       = pm_q;
`endif
endmodule
